s_axi_mem_dp: RTL and testbench

S_AXI_MEM_DP -- requirements
Module: s_axi_mem_dp

---
 rtl/s_axi_mem_dp.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_s_axi_mem_dp.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axi_mem_dp.sv
// AXI4 slave bridging to a simple dual-port memory.
// Write path: AW/W/B FSM with pass-through write strobes, one memory write per accepted beat.
// Read path: AR FSM issuing reads under a credit limit, a fixed-latency return pipeline and a
// read-data FIFO that absorbs R-channel backpressure.
// Ports:
//   s_axi_aclk / s_axi_areset  clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b*   AXI write address, data and response channels
//   s_axi_ar* / s_axi_r*              AXI read address and data channels
//   mem_wr_*                          memory write port (offset address = addr & ~mask)
//   mem_rd_* / mem_rd_data            memory read port, data MEM_RD_LATENCY cycles after enable
module s_axi_mem_dp #(
  parameter int unsigned           ID_WIDTH        = 4,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = 32'hF000_0000,
  parameter int unsigned           MEM_RD_LATENCY  = 1,
  parameter int unsigned           RD_FIFO_DEPTH   = 4
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_strb,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned SizeLog2 = $clog2(StrbW);
  localparam int unsigned CntW     = $clog2(RD_FIFO_DEPTH + 1);
  localparam int unsigned PtrW     = $clog2(RD_FIFO_DEPTH);
  localparam logic [1:0]  RespOkay = 2'b00;
  localparam logic [1:0]  RespSlv  = 2'b10;
  localparam logic [1:0]  RespDec  = 2'b11;

  function automatic logic [1:0] burst_resp(input logic [ADDR_WIDTH-1:0] addr,
                                            input logic [7:0] len, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [1:0] resp;
    resp = RespOkay;
    if ((addr & SLAVE_ADDR_MASK) != (SLAVE_BASE_ADDR & SLAVE_ADDR_MASK)) begin
      resp = RespDec;
    end else if (burst == 2'b11 || size != 3'(SizeLog2) ||
                 (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))) begin
      resp = RespSlv;
    end
    return resp;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] win_mask;
    logic [ADDR_WIDTH-1:0] nxt;
    // Wrap window is (len+1) beats; legal wrap lengths make it a power of two.
    win_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(StrbW)) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   nxt = addr;
      2'b10:   nxt = (addr & ~win_mask) | ((addr + ADDR_WIDTH'(StrbW)) & win_mask);
      default: nxt = (addr & ~ADDR_WIDTH'(StrbW - 1)) + ADDR_WIDTH'(StrbW);
    endcase
    return nxt;
  endfunction

  // ---------------------------------------------------------------- write path
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [1:0]            aw_resp_q, aw_resp_d;

  always_comb begin
    w_state_d     = w_state_q;
    aw_id_d       = aw_id_q;
    aw_addr_d     = aw_addr_q;
    aw_len_d      = aw_len_q;
    aw_burst_d    = aw_burst_q;
    aw_resp_d     = aw_resp_q;
    s_axi_awready = (w_state_q == WIdle) & ~s_axi_areset;
    s_axi_wready  = (w_state_q == WData) & ~s_axi_areset;
    s_axi_bvalid  = (w_state_q == WResp) & ~s_axi_areset;
    case (w_state_q)
      WIdle: if (s_axi_awvalid && s_axi_awready) begin
        aw_id_d    = s_axi_awid;
        aw_addr_d  = s_axi_awaddr;
        aw_len_d   = s_axi_awlen;
        aw_burst_d = s_axi_awburst;
        aw_resp_d  = burst_resp(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
        w_state_d  = WData;
      end
      WData: if (s_axi_wvalid && s_axi_wready) begin
        aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_burst_q);
        if (s_axi_wlast) w_state_d = WResp;
      end
      WResp: if (s_axi_bvalid && s_axi_bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q  <= WIdle;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      aw_resp_q  <= RespOkay;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_burst_q <= aw_burst_d;
      aw_resp_q  <= aw_resp_d;
    end
  end

  assign s_axi_bid   = aw_id_q;
  assign s_axi_bresp = s_axi_bvalid ? aw_resp_q : RespOkay;
  assign mem_wr_en   = s_axi_wvalid & s_axi_wready & (aw_resp_q == RespOkay);
  assign mem_wr_addr = aw_addr_q & ~SLAVE_ADDR_MASK;
  assign mem_wr_data = s_axi_wdata;
  assign mem_wr_strb = s_axi_wstrb;

  // ----------------------------------------------------------------- read path
  typedef enum logic {RIdle, RIssue} r_state_e;
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d, ar_cnt_q, ar_cnt_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [1:0]            ar_resp_q, ar_resp_d;
  logic [CntW-1:0]       fifo_cnt_q, infl_q;
  logic                  credit_ok, rd_issue, rd_last, push, pop;

  // Reserve a FIFO slot for every read in flight so returned data never overflows.
  assign credit_ok = ({1'b0, infl_q} + {1'b0, fifo_cnt_q}) < (CntW + 1)'(RD_FIFO_DEPTH);
  assign rd_issue  = (r_state_q == RIssue) & credit_ok & ~s_axi_areset;
  assign rd_last   = (ar_cnt_q == ar_len_q);
  assign mem_rd_en   = rd_issue & (ar_resp_q == RespOkay);
  assign mem_rd_addr = ar_addr_q & ~SLAVE_ADDR_MASK;

  always_comb begin
    r_state_d     = r_state_q;
    ar_id_d       = ar_id_q;
    ar_addr_d     = ar_addr_q;
    ar_len_d      = ar_len_q;
    ar_cnt_d      = ar_cnt_q;
    ar_burst_d    = ar_burst_q;
    ar_resp_d     = ar_resp_q;
    s_axi_arready = (r_state_q == RIdle) & ~s_axi_areset;
    case (r_state_q)
      RIdle: if (s_axi_arvalid && s_axi_arready) begin
        ar_id_d    = s_axi_arid;
        ar_addr_d  = s_axi_araddr;
        ar_len_d   = s_axi_arlen;
        ar_cnt_d   = '0;
        ar_burst_d = s_axi_arburst;
        ar_resp_d  = burst_resp(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
        r_state_d  = RIssue;
      end
      RIssue: if (rd_issue) begin
        ar_addr_d = next_addr(ar_addr_q, ar_len_q, ar_burst_q);
        ar_cnt_d  = ar_cnt_q + 8'd1;
        if (rd_last) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_q  <= RIdle;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_cnt_q   <= '0;
      ar_burst_q <= '0;
      ar_resp_q  <= RespOkay;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_cnt_q   <= ar_cnt_d;
      ar_burst_q <= ar_burst_d;
      ar_resp_q  <= ar_resp_d;
    end
  end

  // Return pipeline tracks each issue until its data arrives; entries carry id/resp/last so
  // bursts from consecutive ARs keep their own tags.
  logic [MEM_RD_LATENCY-1:0] pipe_vld_q, pipe_last_q;
  logic [1:0]                pipe_resp_q [MEM_RD_LATENCY];
  logic [ID_WIDTH-1:0]       pipe_id_q   [MEM_RD_LATENCY];

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      pipe_vld_q <= '0;  // drops data still returning from before reset
    end else begin
      pipe_vld_q[0] <= rd_issue;
      for (int i = 1; i < MEM_RD_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    pipe_last_q[0] <= rd_last;
    pipe_resp_q[0] <= ar_resp_q;
    pipe_id_q[0]   <= ar_id_q;
    for (int i = 1; i < MEM_RD_LATENCY; i++) begin
      pipe_last_q[i] <= pipe_last_q[i-1];
      pipe_resp_q[i] <= pipe_resp_q[i-1];
      pipe_id_q[i]   <= pipe_id_q[i-1];
    end
  end

  // Read data FIFO
  logic [DATA_WIDTH-1:0]    fifo_data_q [RD_FIFO_DEPTH];
  logic [ID_WIDTH-1:0]      fifo_id_q   [RD_FIFO_DEPTH];
  logic [1:0]               fifo_resp_q [RD_FIFO_DEPTH];
  logic [RD_FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RD_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push         = pipe_vld_q[MEM_RD_LATENCY-1];
  assign s_axi_rvalid = (fifo_cnt_q != '0) & ~s_axi_areset;
  assign pop          = s_axi_rvalid & s_axi_rready;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      infl_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
      infl_q     <= infl_q + CntW'(rd_issue) - CntW'(push);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (push) begin
      // Errored bursts never touched memory, so their beats carry zero data.
      fifo_data_q[wr_ptr_q] <= (pipe_resp_q[MEM_RD_LATENCY-1] == RespOkay) ? mem_rd_data : '0;
      fifo_id_q[wr_ptr_q]   <= pipe_id_q[MEM_RD_LATENCY-1];
      fifo_resp_q[wr_ptr_q] <= pipe_resp_q[MEM_RD_LATENCY-1];
      fifo_last_q[wr_ptr_q] <= pipe_last_q[MEM_RD_LATENCY-1];
    end
  end

  assign s_axi_rdata = fifo_data_q[rd_ptr_q];
  assign s_axi_rid   = fifo_id_q[rd_ptr_q];
  assign s_axi_rresp = fifo_resp_q[rd_ptr_q];
  assign s_axi_rlast = s_axi_rvalid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_s_axi_mem_dp.sv
// Directed bench for s_axi_mem_dp with a 3-cycle memory and a 4-entry read FIFO.
// Memory model returns 0xD0000000 | (offset >> 2) for every read.
module tb_s_axi_mem_dp;
  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [3:0]  s_axi_wstrb, mem_wr_strb;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_wr_addr, mem_wr_data, mem_rd_addr, mem_rd_data;

  s_axi_mem_dp #(.MEM_RD_LATENCY(3), .RD_FIFO_DEPTH(4)) dut (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // 3-cycle read latency memory model
  logic [31:0] st0, st1, st2;
  always @(posedge clk) begin
    if (mem_rd_en) st0 <= 32'hD000_0000 | {2'b00, mem_rd_addr[31:2]};
    st1 <= st0;
    st2 <= st1;
  end
  assign mem_rd_data = st2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic bp = 1'b0;

  logic [31:0] wr_log[$], wr_dat[$], rd_log[$], rb_data[$];
  logic [3:0]  rb_id[$];
  logic [1:0]  rb_resp[$];
  logic        rb_last[$];
  int          rd_cyc[$];

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_log.push_back(mem_wr_addr);
      wr_dat.push_back(mem_wr_data);
    end
    if (mem_rd_en) begin
      rd_log.push_back(mem_rd_addr);
      rd_cyc.push_back(cyc);
    end
    if (s_axi_rvalid && s_axi_rready) begin
      rb_data.push_back(s_axi_rdata);
      rb_id.push_back(s_axi_rid);
      rb_resp.push_back(s_axi_rresp);
      rb_last.push_back(s_axi_rlast);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    s_axi_rready = bp ? (cyc % 4 == 0) : 1'b1;
  endtask

  task automatic obs();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          output logic [1:0] resp, output logic [3:0] bid, output logic done);
    int n;
    tick();
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    obs(); n = 0;
    while (!s_axi_awready && n < 20) begin tick(); obs(); n++; end
    tick();
    s_axi_awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      s_axi_wdata = 32'hCAFE_0000 + k; s_axi_wstrb = 4'hF;
      s_axi_wlast = (k == int'(len)); s_axi_wvalid = 1'b1;
      obs(); n = 0;
      while (!s_axi_wready && n < 20) begin tick(); obs(); n++; end
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    obs(); n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); obs(); n++; end
    resp = s_axi_bresp; bid = s_axi_bid; done = s_axi_bvalid;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         output int lat, output logic done);
    int n, s;
    s = rb_data.size();
    tick();
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    obs(); n = 0;
    while (!s_axi_arready && n < 20) begin tick(); obs(); n++; end
    tick();
    s_axi_arvalid = 1'b0;
    lat = 1;
    obs();
    while (!s_axi_rvalid && lat < 50) begin tick(); lat++; obs(); end
    n = 0;
    while (rb_data.size() < s + int'(len) + 1 && n < 500) begin tick(); obs(); n++; end
    done = (rb_data.size() == s + int'(len) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [3:0]  bid;
    logic        done;
    int          lat, w0, r0, b0, n;
    logic [31:0] wrap_addr [4];
    logic [31:0] wrap_data [4];
    wrap_addr = '{32'h38, 32'h3C, 32'h30, 32'h34};
    wrap_data = '{32'hD000_000E, 32'hD000_000F, 32'hD000_000C, 32'hD000_000D};

    areset = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;

    // Reset state
    tick(); tick(); obs();
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_bresp", s_axi_bresp, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    tick();
    areset = 1'b0;
    obs();
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_arready", s_axi_arready, 1);

    // INCR write, len=3
    w0 = wr_log.size();
    do_write(4'h5, 32'h4000_0010, 8'd3, 3'd2, 2'b01, resp, bid, done);
    chk("incr_b_done", done, 1);
    chk("incr_bresp", resp, 2'b00);
    chk("incr_bid", bid, 4'h5);
    chk("incr_wr_count", wr_log.size() - w0, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("incr_wr_addr[%0d]", k), wr_log[w0 + k], 32'h10 + 4 * k);
      chk($sformatf("incr_wr_data[%0d]", k), wr_dat[w0 + k], 32'hCAFE_0000 + k);
    end

    // Decode miss write: beats accepted, no memory access
    w0 = wr_log.size();
    do_write(4'hA, 32'h5000_0000, 8'd1, 3'd2, 2'b01, resp, bid, done);
    chk("decerr_b_done", done, 1);
    chk("decerr_bresp", resp, 2'b11);
    chk("decerr_bid", bid, 4'hA);
    chk("decerr_no_wr", wr_log.size() - w0, 0);

    // Reserved burst type write
    w0 = wr_log.size();
    do_write(4'h3, 32'h4000_0020, 8'd0, 3'd2, 2'b11, resp, bid, done);
    chk("slverr_bresp", resp, 2'b10);
    chk("slverr_no_wr", wr_log.size() - w0, 0);

    // WRAP read, len=3
    r0 = rd_log.size(); b0 = rb_data.size();
    do_read(4'h3, 32'h4000_0038, 8'd3, 3'd2, 2'b10, lat, done);
    chk("wrap_done", done, 1);
    chk("wrap_latency", lat, 5);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_rd_addr[%0d]", k), rd_log[r0 + k], wrap_addr[k]);
      chk($sformatf("wrap_rdata[%0d]", k), rb_data[b0 + k], wrap_data[k]);
      chk($sformatf("wrap_rlast[%0d]", k), rb_last[b0 + k], k == 3);
      chk($sformatf("wrap_rid[%0d]", k), rb_id[b0 + k], 4'h3);
      chk($sformatf("wrap_rresp[%0d]", k), rb_resp[b0 + k], 2'b00);
    end

    // Size error read: zero data, SLVERR, no memory access
    r0 = rd_log.size(); b0 = rb_data.size();
    do_read(4'h1, 32'h4000_0100, 8'd1, 3'd1, 2'b01, lat, done);
    chk("rslv_done", done, 1);
    chk("rslv_no_rd", rd_log.size() - r0, 0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rslv_rdata[%0d]", k), rb_data[b0 + k], 0);
      chk($sformatf("rslv_rresp[%0d]", k), rb_resp[b0 + k], 2'b10);
      chk($sformatf("rslv_rlast[%0d]", k), rb_last[b0 + k], k == 1);
    end

    // Backpressure: len=15, rready one cycle in four
    bp = 1'b1;
    r0 = rd_log.size(); b0 = rb_data.size();
    do_read(4'h9, 32'h4000_0080, 8'd15, 3'd2, 2'b01, lat, done);
    bp = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_rd_count", rd_log.size() - r0, 16);
    chk("bp_rd_stalled", (rd_cyc[r0 + 15] - rd_cyc[r0]) > 15, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("bp_rdata[%0d]", k), rb_data[b0 + k], 32'hD000_0020 + k);
      chk($sformatf("bp_rlast[%0d]", k), rb_last[b0 + k], k == 15);
      chk($sformatf("bp_rid[%0d]", k), rb_id[b0 + k], 4'h9);
    end
    tick(); obs();
    chk("bp_no_extra", rb_data.size() - b0, 16);

    // AW and AR in the same cycle
    b0 = rb_data.size();
    tick();
    s_axi_awid = 4'h2; s_axi_awaddr = 32'h4000_0040; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    s_axi_arid = 4'h4; s_axi_araddr = 32'h4000_0044; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    obs();
    chk("conc_awready", s_axi_awready, 1);
    chk("conc_arready", s_axi_arready, 1);
    tick();
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    obs();
    chk("conc_mem_wr_en", mem_wr_en, 1);
    chk("conc_mem_rd_en", mem_rd_en, 1);
    chk("conc_mem_wr_addr", mem_wr_addr, 32'h40);
    chk("conc_mem_rd_addr", mem_rd_addr, 32'h44);
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    obs(); n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); obs(); n++; end
    chk("conc_bvalid", s_axi_bvalid, 1);
    chk("conc_bid", s_axi_bid, 4'h2);
    tick();
    s_axi_bready = 1'b0;
    n = 0;
    while (rb_data.size() < b0 + 1 && n < 50) begin tick(); obs(); n++; end
    chk("conc_r_count", rb_data.size() - b0, 1);
    if (rb_data.size() > b0) begin
      chk("conc_rdata", rb_data[b0], 32'hD000_0011);
      chk("conc_rid", rb_id[b0], 4'h4);
    end

    // Reset during beat 2 of a len=7 read
    b0 = rb_data.size();
    tick();
    s_axi_arid = 4'h6; s_axi_araddr = 32'h4000_0000; s_axi_arlen = 8'd7;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    obs(); n = 0;
    while (!s_axi_arready && n < 20) begin tick(); obs(); n++; end
    tick();
    s_axi_arvalid = 1'b0;
    obs(); n = 0;
    while (rb_data.size() < b0 + 2 && n < 100) begin tick(); obs(); n++; end
    chk("mid_rst_two_beats", rb_data.size() - b0, 2);
    tick();
    areset = 1'b1;
    obs();
    tick();
    areset = 1'b0;
    obs();
    chk("mid_rst_rvalid", s_axi_rvalid, 0);
    chk("mid_rst_arready", s_axi_arready, 1);
    chk("mid_rst_awready", s_axi_awready, 1);
    for (int k = 0; k < 12; k++) begin tick(); obs(); end
    chk("mid_rst_no_more_beats", rb_data.size() - b0, 2);

    // Recovery read after reset
    b0 = rb_data.size();
    do_read(4'h7, 32'h4000_0004, 8'd0, 3'd2, 2'b01, lat, done);
    chk("recov_done", done, 1);
    chk("recov_latency", lat, 5);
    if (rb_data.size() > b0) begin
      chk("recov_rdata", rb_data[b0], 32'hD000_0001);
      chk("recov_rlast", rb_last[b0], 1);
      chk("recov_rid", rb_id[b0], 4'h7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
